// File: rtl/frame_write_sequencer_pkg.sv
// Shared frame-manager definitions: source-select width, sequencer state codes, draw-area defaults.
package frame_write_sequencer_pkg;

    localparam int SOURCE_SEL_ADDRW = 2;
    localparam int DRAW_WIDTH_DEF   = 640;
    localparam int DRAW_HEIGHT_DEF  = 480;

    typedef logic [2:0] fws_state_t;

    localparam fws_state_t ST_IDLE       = 3'd0;
    localparam fws_state_t ST_SELECT     = 3'd1;
    localparam fws_state_t ST_REQUEST    = 3'd2;
    localparam fws_state_t ST_WAIT_START = 3'd3;
    localparam fws_state_t ST_ACTIVE     = 3'd4;
    localparam fws_state_t ST_NEXT       = 3'd5;
    localparam fws_state_t ST_DONE       = 3'd6;

endpackage

// File: rtl/frame_write_sequencer_fb_addr_gen.sv
// Range check, linear address y*DRAW_WIDTH+x and one-cycle registered framebuffer write port.
module fb_addr_gen
    import frame_write_sequencer_pkg::*;
#(
    parameter int COLOR_DEPTH = 9,
    parameter int DRAW_WIDTH  = DRAW_WIDTH_DEF,
    parameter int DRAW_HEIGHT = DRAW_HEIGHT_DEF,
    parameter int FB_ADDRW    = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic [31:0]            x_addr,
    input  logic [31:0]            y_addr,
    input  logic [COLOR_DEPTH-1:0] color,
    output logic                   fb_we,
    output logic [FB_ADDRW-1:0]    fb_addr,
    output logic [COLOR_DEPTH-1:0] fb_data
);

    function automatic logic in_frame(input logic [31:0] x, input logic [31:0] y);
        return (x < 32'(DRAW_WIDTH)) && (y < 32'(DRAW_HEIGHT));
    endfunction

    function automatic logic [FB_ADDRW-1:0] lin_addr(input logic [31:0] x, input logic [31:0] y);
        logic [FB_ADDRW-1:0] w;
        w = FB_ADDRW'(DRAW_WIDTH);
        return FB_ADDRW'(y) * w + FB_ADDRW'(x);
    endfunction

    logic                   vld_p1;
    logic [FB_ADDRW-1:0]    addr_p1;
    logic [COLOR_DEPTH-1:0] data_p1;

    // p0 -> p1: bus sample to framebuffer port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= capture && in_frame(x_addr, y_addr);
            if (capture) begin
                addr_p1 <= lin_addr(x_addr, y_addr);
                data_p1 <= color;
            end
        end
    end

    assign fb_we   = vld_p1;
    assign fb_addr = addr_p1;
    assign fb_data = data_p1;

endmodule

// File: rtl/frame_write_sequencer.sv
// Grants the draw-source bus to each populated source in turn and double-buffers the frame.
// Optional start timeout on silent sources: define FRAME_WRITE_SEQ_TIMEOUT_EN.
module frame_write_sequencer
    import frame_write_sequencer_pkg::*;
#(
    parameter int                     NUM_SOURCES   = 4,
    parameter logic [NUM_SOURCES-1:0] SOURCE_MASK   = 4'b1111,
    parameter int                     COLOR_DEPTH   = 9,
    parameter int                     DRAW_WIDTH    = DRAW_WIDTH_DEF,
    parameter int                     DRAW_HEIGHT   = DRAW_HEIGHT_DEF,
    parameter int                     FB_ADDRW      = 19
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
    ,
    parameter int                     START_TIMEOUT = 16
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    input  logic                        write_active,
    input  logic [COLOR_DEPTH-1:0]      write_color_data,
    input  logic [31:0]                 write_x_addr,
    input  logic [31:0]                 write_y_addr,
    output logic                        fb_we,
    output logic [FB_ADDRW-1:0]         fb_addr,
    output logic [COLOR_DEPTH-1:0]      fb_data,
    output logic                        fb_bank,
    output logic                        display_bank,
    output logic                        frame_done,
    output logic                        frame_overrun
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
    ,
    output logic                        source_timeout
`endif
);

    localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SEL = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);

    fws_state_t                  state;
    logic [SOURCE_SEL_ADDRW-1:0] sel;
    logic                        capture;

`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(START_TIMEOUT) + 1;
    logic [TO_W-1:0] wait_cnt;
`endif

    // A compliant source's first pixel arrives with write_active, while still in WAIT_START
    assign capture = write_active && ((state == ST_WAIT_START) || (state == ST_ACTIVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sel           <= '0;
            write_awaited <= 1'b0;
            fb_bank       <= 1'b0;
            display_bank  <= 1'b1;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
            wait_cnt       <= '0;
            source_timeout <= 1'b0;
`endif
        end else begin
            write_awaited <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= frame_start && (state != ST_IDLE) && (state != ST_DONE);
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
            source_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        sel   <= '0;
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (SOURCE_MASK[sel]) begin
                        write_awaited <= 1'b1;
                        state         <= ST_REQUEST;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_REQUEST: begin
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
                    wait_cnt <= TO_W'(1);
`endif
                    state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (write_active) begin
                        state <= ST_ACTIVE;
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
                    end else if (wait_cnt == TO_W'(START_TIMEOUT - 1)) begin
                        source_timeout <= 1'b1;
                        state          <= ST_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_ACTIVE: begin
                    if (!write_active) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (sel == LAST_SEL) begin
                        frame_done <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        sel   <= sel + 1'b1;
                        state <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    if (frame_start) begin
                        display_bank <= fb_bank;
                        fb_bank      <= ~fb_bank;
                        sel          <= '0;
                        state        <= ST_SELECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign write_source_sel = sel;

    fb_addr_gen #(
        .COLOR_DEPTH (COLOR_DEPTH),
        .DRAW_WIDTH  (DRAW_WIDTH),
        .DRAW_HEIGHT (DRAW_HEIGHT),
        .FB_ADDRW    (FB_ADDRW)
    ) u_fb_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .capture (capture),
        .x_addr  (write_x_addr),
        .y_addr  (write_y_addr),
        .color   (write_color_data),
        .fb_we   (fb_we),
        .fb_addr (fb_addr),
        .fb_data (fb_data)
    );

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Bench for frame_write_sequencer: sources 0 and 2 populated, randomized pixel bursts vs. a scoreboard.
module tb_frame_write_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [1:0]  write_source_sel;
    logic        write_awaited;
    logic        write_active;
    logic [8:0]  write_color_data;
    logic [31:0] write_x_addr;
    logic [31:0] write_y_addr;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fb_bank;
    logic        display_bank;
    logic        frame_done;
    logic        frame_overrun;
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
    logic        source_timeout;
`endif

    frame_write_sequencer #(
        .NUM_SOURCES (4),
        .SOURCE_MASK (4'b0101),
        .COLOR_DEPTH (9),
        .DRAW_WIDTH  (640),
        .DRAW_HEIGHT (480),
        .FB_ADDRW    (19)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .write_source_sel (write_source_sel),
        .write_awaited    (write_awaited),
        .write_active     (write_active),
        .write_color_data (write_color_data),
        .write_x_addr     (write_x_addr),
        .write_y_addr     (write_y_addr),
        .fb_we            (fb_we),
        .fb_addr          (fb_addr),
        .fb_data          (fb_data),
        .fb_bank          (fb_bank),
        .display_bank     (display_bank),
        .frame_done       (frame_done),
        .frame_overrun    (frame_overrun)
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
        ,
        .source_timeout   (source_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [8:0]  c;
    } px_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          gq[$];
    px_t         fixed_q[$];
    int          done_cnt = 0;
    int          ovr_cnt  = 0;
    int          dbl_cnt  = 0;
    int          to_cnt   = 0;
    logic        prev_awaited = 1'b0;

    function automatic logic [31:0] pk(input int addr, input logic [8:0] c);
        logic [18:0] a;
        a = addr[18:0];
        return {4'b0, a, c};
    endfunction

    always @(negedge clk) begin
        if (fb_we) obs_q.push_back({4'b0, fb_addr, fb_data});
        if (write_awaited) gq.push_back(int'(write_source_sel));
        if (write_awaited && prev_awaited) dbl_cnt++;
        prev_awaited = write_awaited;
        if (frame_done) done_cnt++;
        if (frame_overrun) ovr_cnt++;
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
        if (source_timeout) to_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_frame();
        obs_q.delete();
        exp_q.delete();
        gq.delete();
        done_cnt = 0;
        ovr_cnt  = 0;
    endtask

    task automatic pulse_fs();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    // Compliant source: raise write_active two cycles after the grant cycle, stream n pixels.
    task automatic serve(input int id, input int n, input int ovr_at);
        bit  seen;
        px_t p;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (write_awaited) seen = 1'b1;
        end
        check("grant_seen", 32'(seen), 32'd1);
        check("grant_id", 32'(write_source_sel), 32'(id));
        @(posedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            if (fixed_q.size() > 0) begin
                p = fixed_q.pop_front();
            end else begin
                p.x = 32'($urandom_range(0, 699));
                p.y = 32'($urandom_range(0, 519));
                p.c = 9'($urandom);
            end
            write_active     = 1'b1;
            write_x_addr     = p.x;
            write_y_addr     = p.y;
            write_color_data = p.c;
            frame_start      = (k == ovr_at);
            if (p.x < 640 && p.y < 480) exp_q.push_back(pk(int'(p.y) * 640 + int'(p.x), p.c));
            @(posedge clk); #1;
        end
        write_active = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_frame();
        check("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("wr_entry", obs_q[i], exp_q[i]);
        check("grant_count", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            check("grant_first", 32'(gq[0]), 32'd0);
            check("grant_second", 32'(gq[1]), 32'd2);
        end
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        frame_start      = 1'b0;
        write_active     = 1'b0;
        write_color_data = '0;
        write_x_addr     = '0;
        write_y_addr     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel", 32'(write_source_sel), 32'd0);
        check("rst_awaited", 32'(write_awaited), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_fb_bank", 32'(fb_bank), 32'd0);
        check("rst_display_bank", 32'(display_bank), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_overrun", 32'(frame_overrun), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Frame 1: first frame, no swap; frame corners and out-of-range pixels
        clear_frame();
        pulse_fs();
        check("f1_fb_bank", 32'(fb_bank), 32'd0);
        fixed_q.push_back('{x: 32'd0, y: 32'd0, c: 9'h1A5});
        fixed_q.push_back('{x: 32'd639, y: 32'd479, c: 9'h05A});
        serve(0, 12, -1);
        fixed_q.push_back('{x: 32'd640, y: 32'd5, c: 9'h111});
        fixed_q.push_back('{x: 32'd3, y: 32'd480, c: 9'h122});
        fixed_q.push_back('{x: 32'd3, y: 32'd1, c: 9'h133});
        fixed_q.push_back('{x: 32'hFFFF_FFFF, y: 32'd0, c: 9'h144});
        serve(2, 10, -1);
        wait_done();
        compare_frame();
        if (obs_q.size() >= 3) begin
            check("first_addr", 32'(obs_q[0][27:9]), 32'd0);
            check("corner_addr", 32'(obs_q[1][27:9]), 32'd307199);
        end
        check("f1_overrun", 32'(ovr_cnt), 32'd0);
        check("f1_end_fb_bank", 32'(fb_bank), 32'd0);
        check("f1_end_display_bank", 32'(display_bank), 32'd1);

        // Frame 2: swap, then frame_start during ACTIVE is an overrun without swap
        clear_frame();
        pulse_fs();
        @(negedge clk);
        check("f2_fb_bank", 32'(fb_bank), 32'd1);
        check("f2_display_bank", 32'(display_bank), 32'd0);
        serve(0, 8, 3);
        serve(2, 6, -1);
        wait_done();
        compare_frame();
        check("f2_overrun", 32'(ovr_cnt), 32'd1);
        check("f2_end_fb_bank", 32'(fb_bank), 32'd1);
        check("f2_end_display_bank", 32'(display_bank), 32'd0);

        // Frame 3: the frame_start after DONE swaps back
        clear_frame();
        pulse_fs();
        @(negedge clk);
        check("f3_fb_bank", 32'(fb_bank), 32'd0);
        check("f3_display_bank", 32'(display_bank), 32'd1);
        serve(0, 7, -1);
        serve(2, 7, -1);
        wait_done();
        compare_frame();
        check("f3_overrun", 32'(ovr_cnt), 32'd0);

        // Frame 4: swap, then asynchronous reset mid-frame
        clear_frame();
        pulse_fs();
        @(negedge clk);
        check("f4_fb_bank", 32'(fb_bank), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_fb_bank", 32'(fb_bank), 32'd0);
        check("mid_rst_display_bank", 32'(display_bank), 32'd1);
        check("mid_rst_awaited", 32'(write_awaited), 32'd0);
        check("mid_rst_sel", 32'(write_source_sel), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Frame 5: first frame after reset again draws without a swap
        clear_frame();
        pulse_fs();
        @(negedge clk);
        check("f5_fb_bank", 32'(fb_bank), 32'd0);
        check("f5_display_bank", 32'(display_bank), 32'd1);
        serve(0, 5, -1);
        serve(2, 5, -1);
        wait_done();
        compare_frame();

        check("single_cycle_grant", 32'(dbl_cnt), 32'd0);
`ifdef FRAME_WRITE_SEQ_TIMEOUT_EN
        check("no_timeout", 32'(to_cnt), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
